// File: rtl/network_mul_pkg.sv
// network_mul_pkg: shared multiplier widths, pipeline latency and the default-width pipe tag
package network_mul_pkg;
    localparam int MUL_A_W = 16;
    localparam int MUL_B_W = 11;
    localparam int MUL_P_W = 27;
    localparam int MUL_LAT = 2;
    localparam int IDW     = 2;
    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } tag_t;
endpackage

// File: rtl/network_mul_mul_16s_11ns_27_3_1.sv
// network_mul_mul_16s_11ns_27_3_1: two ce-gated stages, 16-bit signed din0 x 11-bit unsigned din1 -> 27-bit signed dout
module network_mul_mul_16s_11ns_27_3_1
    import network_mul_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [MUL_A_W-1:0] din0,
    input  logic [MUL_B_W-1:0] din1,
    output logic [MUL_P_W-1:0] dout
);
    logic [MUL_A_W-1:0] a_q;
    logic [MUL_B_W-1:0] b_q;
    logic [MUL_P_W-1:0] p_q;
    logic               unused_reset;
    assign unused_reset = reset;
    always_ff @(posedge clk) begin
        if (ce) begin
            a_q <= din0;
            b_q <= din1;
            p_q <= $signed({{(MUL_P_W-MUL_A_W){a_q[MUL_A_W-1]}}, a_q}) * $signed({{(MUL_P_W-MUL_B_W){1'b0}}, b_q});
        end
    end
    assign dout = p_q;
endmodule

// File: rtl/network_mul_rr_arbiter.sv
// network_mul_rr_arbiter: round-robin sharing of one pipelined 16s x 11u multiplier among NREQ lanes, ids carried in a tag pipe
module network_mul_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = network_mul_pkg::MUL_LAT
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     en,
    input  logic [NREQ-1:0]                          req_valid,
    output logic [NREQ-1:0]                          req_ready,
    input  logic [NREQ*network_mul_pkg::MUL_A_W-1:0] req_a,
    input  logic [NREQ*network_mul_pkg::MUL_B_W-1:0] req_b,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic [IDW-1:0]                           res_id,
    output logic [network_mul_pkg::MUL_P_W-1:0]      res_data,
    output logic                                     busy
);
    localparam int AW = network_mul_pkg::MUL_A_W;
    localparam int BW = network_mul_pkg::MUL_B_W;
    logic               ce;
    logic               accept;
    logic               found;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gnt_id;
    logic [MUL_LAT-1:0] tag_v;
    logic [IDW-1:0]     tag_id [MUL_LAT];
    logic [AW-1:0]      lane_a [NREQ];
    logic [BW-1:0]      lane_b [NREQ];
    logic [AW-1:0]      din0;
    logic [BW-1:0]      din1;

    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
        logic [IDW:0] r;
        int           i;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            i = (int'(p) + k) % NREQ;
            if (v[IDW'(i)]) r = {1'b1, IDW'(i)};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lane_a[i] = req_a[i*AW +: AW];
            lane_b[i] = req_b[i*BW +: BW];
        end
    end

    assign {found, gnt_id} = rr_pick(req_valid, ptr);
    assign ce        = !(tag_v[MUL_LAT-1] && !res_ready);
    assign accept    = ce && en && found;
    assign req_ready = (reset && accept) ? NREQ'(1) << gnt_id : '0;
    assign din0      = accept ? lane_a[gnt_id] : '0;
    assign din1      = accept ? lane_b[gnt_id] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v <= '0;
            ptr   <= '0;
            for (int k = 0; k < MUL_LAT; k++) tag_id[k] <= '0;
        end else if (ce) begin
            tag_v     <= MUL_LAT'({tag_v, accept});
            tag_id[0] <= gnt_id;
            for (int k = 1; k < MUL_LAT; k++) tag_id[k] <= tag_id[k-1];
            if (accept) ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    assign res_valid = tag_v[MUL_LAT-1];
    assign res_id    = tag_id[MUL_LAT-1];
    assign busy      = |tag_v;

    network_mul_mul_16s_11ns_27_3_1 u_mul (
        .clk   (clk),
        .reset (1'b0),
        .ce    (ce),
        .din0  (din0),
        .din1  (din1),
        .dout  (res_data)
    );
endmodule
